ext_bus_arbiter: RTL and testbench
==================================

# ext_bus_arbiter

Sequences and shares the chip's byte-serial external memory bus between two 32-bit requesters (CPU port 0, debug/DMA port 1). Sits between the requester ports and the 8-bit pad interface in the top-level wrapper. It serialises each 32-bit address/data transaction into fixed byte phases, assembles read data little-endian and returns a one-cycle acknowledge.

## Interface

Parameters:
- none (bus width fixed at 8, word width fixed at 32)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  transaction request; held high with stable we/addr/wdata until ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address
- wdata0 / wdata1  in  32  write data
- ack0 / ack1  out  1  one-cycle completion pulse to the granted requester
- rdata  out  32  read data; valid in the ack cycle, held until the next read completes
- gnt  out  2  one-hot owner of the current transaction; 0 in IDLE
- busy  out  1  high in every state except IDLE
- bus_out  out  8  address / command byte to pads
- io_in  in  8  bidirectional pad input path
- io_out  out  8  bidirectional pad output path
- io_oe  out  8  pad output enable, 8'hFF or 8'h00

## Operation

- States: IDLE, A0, A1, A2, A3, CMD, R0, R1, R2, R3, DONE.
- IDLE: sample req0/req1; if any high, latch winner's we/addr/wdata into internal regs, set gnt, go A0; else stay.
- Aн (n=0..3): bus_out = addr[8n+7:8n]; io_out = wdata[8n+7:8n]; io_oe = 8'hFF if write else 8'h00.
- CMD: bus_out = {6'b0, owner_id, we}; io_out = 0; io_oe = 0. Next R0 if read, DONE if write.
- Rn: io_oe = 0; io_in captured into rdata[8n+7:8n] at the end of the cycle.
- DONE: ack of owner = 1 for exactly this cycle; next IDLE; gnt cleared on leaving.
- Writes never modify rdata. Latched addr/wdata ignore requester changes after grant.
- Requester drops req at the edge that ends the ack cycle; a req still high in the following IDLE is a new transaction.
- Reset values: state IDLE; ack0/ack1 0; rdata 0; gnt 0; busy 0; bus_out 0; io_out 0; io_oe 0; round-robin pointer favours requester 0.
- Reset mid-transaction: asynchronously abort, io_oe 0 immediately, no ack issued, latched request discarded.

## Timing

- All outputs registered (driven from state and latched regs); no combinational path from req to any output.
- Read: req sampled in IDLE cycle T; A0 at T+1; CMD at T+5; R0..R3 at T+6..T+9; ack at T+10. 11 cycles IDLE-to-ack.
- Write: ack at T+6. 7 cycles IDLE-to-ack.
- Minimum one IDLE cycle between consecutive transactions; back-to-back read throughput 1 per 11 cycles.
- Arbitration only in IDLE; a request raised mid-transaction waits, no preemption.

## Configuration

- ROUND_ROBIN_EN defined: 1-bit last-owner pointer; when both req high in IDLE, the requester not granted last wins; single requests always win; pointer updated at grant.
- ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins simultaneous requests; no pointer state.

## Test plan

- Single read on port 0, addr 32'h1234_5678, io_in driven 8'hEF,8'hBE,8'hAD,8'hDE in R0..R3 -> bus_out 78,56,34,12 then CMD 8'h00; rdata 32'hDEAD_BEEF with ack0 at T+10; io_oe 0 throughout.
- Single write on port 1, addr 32'h0000_0010, wdata 32'hCAFE_F00D -> io_out 0D,F0,FE,CA with io_oe 8'hFF in A0..A3; CMD 8'h03; ack1 at T+6; rdata unchanged.
- Both req high continuously, reads -> with ROUND_ROBIN_EN grants alternate 0,1,0,1; without it port 0 granted every transaction, port 1 starved.
- req1 raised during port 0 transaction at A2 -> port 1 granted in the IDLE after port 0 ack, never mid-transaction.
- rst asserted during R1 of a read -> io_oe 0, gnt 0, busy 0 immediately; no ack; after release with req0 still high a full new 11-cycle transaction runs.
- Requester changes addr0 after grant -> bus_out still carries the address latched in IDLE.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// Two-port arbiter serialising 32-bit transactions onto a byte-wide external bus.
// Define ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ext_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [7:0]  bus_out,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oe
);

  typedef enum logic [3:0] {IDLE, A0, A1, A2, A3, CMD, R0, R1, R2, R3, DONE} state_t;

  state_t      state, state_nxt;
  logic        owner;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        any_req;
  logic        win;

  assign any_req = req0 | req1;

`ifdef ROUND_ROBIN_EN
  logic last;  // owner of the most recent grant; resets to 1 so port 0 wins first
  assign win = (req0 & req1) ? ~last : req1;
`else
  assign win = ~req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata   <= '0;
`ifdef ROUND_ROBIN_EN
      last    <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        owner   <= win;
        we_r    <= win ? we1 : we0;
        addr_r  <= win ? addr1 : addr0;
        wdata_r <= win ? wdata1 : wdata0;
`ifdef ROUND_ROBIN_EN
        last    <= win;
`endif
      end
      case (state)
        R0:      rdata[7:0]   <= io_in;
        R1:      rdata[15:8]  <= io_in;
        R2:      rdata[23:16] <= io_in;
        R3:      rdata[31:24] <= io_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = A0;
      A0:      state_nxt = A1;
      A1:      state_nxt = A2;
      A2:      state_nxt = A3;
      A3:      state_nxt = CMD;
      CMD:     state_nxt = we_r ? DONE : R0;
      R0:      state_nxt = R1;
      R1:      state_nxt = R2;
      R2:      state_nxt = R3;
      R3:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only registered state, so reset clears them immediately.
  always_comb begin
    bus_out = 8'h00;
    io_out  = 8'h00;
    io_oe   = 8'h00;
    case (state)
      A0: begin
        bus_out = addr_r[7:0];
        io_out  = wdata_r[7:0];
        io_oe   = {8{we_r}};
      end
      A1: begin
        bus_out = addr_r[15:8];
        io_out  = wdata_r[15:8];
        io_oe   = {8{we_r}};
      end
      A2: begin
        bus_out = addr_r[23:16];
        io_out  = wdata_r[23:16];
        io_oe   = {8{we_r}};
      end
      A3: begin
        bus_out = addr_r[31:24];
        io_out  = wdata_r[31:24];
        io_oe   = {8{we_r}};
      end
      CMD:     bus_out = {6'b0, owner, we_r};
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign gnt  = (state == IDLE) ? 2'b00 : {owner, ~owner};
  assign ack0 = (state == DONE) & ~owner;
  assign ack1 = (state == DONE) & owner;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: byte phasing, latency, arbitration, reset abort.
module tb_ext_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic [1:0]  gnt;
  logic        busy;
  logic [7:0]  bus_out, io_in, io_out, io_oe;

  int n_checks = 0;
  int n_fails  = 0;

  ext_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt), .busy(busy),
    .bus_out(bus_out), .io_in(io_in), .io_out(io_out), .io_oe(io_oe)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, {ack1, ack0}, 0);
    chk({tag, "_bus"}, bus_out, 0);
    chk({tag, "_oe"}, io_oe, 0);
  endtask

  // Called during an IDLE cycle with the request(s) already driven.
  // mode 1: raise req1 at A2; mode 2: change port-0 addr/wdata after grant.
  task automatic txn(input int own, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int mode);
    logic       o;
    logic [1:0] g;
    o = own[0];
    g = o ? 2'b10 : 2'b01;
    step();
    for (int n = 0; n < 4; n++) begin
      if (mode == 2 && n == 0) begin
        addr0  = 32'hFFFF_0000;
        wdata0 = 32'h0BAD_0BAD;
      end
      if (mode == 1 && n == 2) req1 = 1'b1;
      chk("addr_byte", bus_out, a[8*n +: 8]);
      chk("addr_oe", io_oe, w ? 8'hFF : 8'h00);
      if (w) chk("wdata_byte", io_out, wd[8*n +: 8]);
      chk("addr_gnt", gnt, g);
      chk("addr_busy", busy, 1);
      step();
    end
    chk("cmd_byte", bus_out, {6'b0, o, w});
    chk("cmd_oe", io_oe, 0);
    chk("cmd_io_out", io_out, 0);
    chk("cmd_ack", {ack1, ack0}, 0);
    step();
    if (!w) begin
      for (int n = 0; n < 4; n++) begin
        io_in = rd[8*n +: 8];
        chk("rd_oe", io_oe, 0);
        chk("rd_ack", {ack1, ack0}, 0);
        chk("rd_gnt", gnt, g);
        step();
      end
    end
    io_in = 8'h00;
    chk("done_ack", {ack1, ack0}, g);
    chk("done_rdata", rdata, rd);
    chk("done_gnt", gnt, g);
    step();
    chk("post_ack", {ack1, ack0}, 0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; io_in = 0;
    #12;
    chk_idle("reset");
    chk("reset_rdata", rdata, 0);
    chk("reset_io_out", io_out, 0);
    rst = 1'b0;

    // Single read on port 0
    addr0 = 32'h1234_5678; we0 = 0; req0 = 1;
    txn(0, 0, 32'h1234_5678, 0, 32'hDEAD_BEEF, 0);
    req0 = 0;
    chk_idle("read_idle");

    // Single write on port 1; rdata must keep the previous read value
    addr1 = 32'h0000_0010; wdata1 = 32'hCAFE_F00D; we1 = 1; req1 = 1;
    txn(1, 1, 32'h0000_0010, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0);
    req1 = 0;
    chk_idle("write_idle");

    // req1 raised mid-transaction waits for the next IDLE
    addr0 = 32'h0000_0100; we0 = 0; req0 = 1;
    addr1 = 32'h0000_0200; we1 = 0;
    txn(0, 0, 32'h0000_0100, 0, 32'h1122_3344, 1);
    req0 = 0;
    chk_idle("wait_idle");
    txn(1, 0, 32'h0000_0200, 0, 32'h5566_7788, 0);
    req1 = 0;
    chk_idle("wait_idle2");

    // Both requesting continuously
    addr0 = 32'h0000_1000; addr1 = 32'h0000_2000; we0 = 0; we1 = 0;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      txn(k % 2, 0, (k % 2) ? 32'h0000_2000 : 32'h0000_1000, 0, 32'hA000_0000 + k, 0);
`else
      txn(0, 0, 32'h0000_1000, 0, 32'hA000_0000 + k, 0);
`endif
      if (k == 3) begin
        req0 = 0;
        req1 = 0;
      end
      chk_idle("contend_idle");
    end
    step();

    // Requester changes addr/wdata after grant
    addr0 = 32'hA5A5_0001; wdata0 = 32'h0102_0304; we0 = 1; req0 = 1;
    txn(0, 1, 32'hA5A5_0001, 32'h0102_0304, 32'hA000_0003, 2);
    req0 = 0;
    chk_idle("latch_idle");

    // Reset during R1 of a read
    addr0 = 32'h0000_3000; we0 = 0; req0 = 1;
    step();
    repeat (6) step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_idle("abort");
    chk("abort_rdata", rdata, 0);
    step();
    chk_idle("abort_hold");
    #3;
    rst = 1'b0;
    txn(0, 0, 32'h0000_3000, 0, 32'h0BAD_F00D, 0);
    req0 = 0;
    chk_idle("rerun_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
